// File: rtl/fpmult32_top.sv
// fpmult32_top: IEEE-754 binary32 multiplier, RNE rounding, flush-to-zero, one registered output stage.
// Define BFLOAT16_EN to multiply bfloat16 operands held in bits [31:16] instead.
module fpmult32_top #(
    parameter int BIT_WIDTH  = 32,
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int BIAS       = 127
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] a_operand,
    input  logic [BIT_WIDTH-1:0] b_operand,
    output logic [BIT_WIDTH-1:0] result,
    output logic                 exception,
    output logic                 overflow,
    output logic                 underflow
);
`ifdef BFLOAT16_EN
    localparam int MW = 7;
`else
    localparam int MW = MANT_WIDTH;
`endif
    localparam int EW = EXP_WIDTH;
    localparam int MT = MANT_WIDTH;
    localparam logic [EW-1:0] EMAX = '1;

    logic                 sign;
    logic [EW-1:0]        ea, eb;
    logic [MW-1:0]        ma, mb, mant;
    logic [2*MW+1:0]      prod;
    logic                 norm, guard, sticky, rnd;
    logic [MW:0]          mant_r;
    logic [9:0]           e_res;
    logic                 a_nan, b_nan, a_zero, b_zero;
    logic [BIT_WIDTH-1:0] res_d;
    logic                 exc_d, ovf_d, unf_d;

    assign sign   = a_operand[BIT_WIDTH-1] ^ b_operand[BIT_WIDTH-1];
    assign ea     = a_operand[MT +: EW];
    assign eb     = b_operand[MT +: EW];
    assign ma     = a_operand[MT-1 -: MW];
    assign mb     = b_operand[MT-1 -: MW];
    assign a_zero = ea == '0;
    assign b_zero = eb == '0;
    assign a_nan  = ea == EMAX && ma != '0;
    assign b_nan  = eb == EMAX && mb != '0;

    assign prod   = {{(MW+1){1'b0}}, 1'b1, ma} * {{(MW+1){1'b0}}, 1'b1, mb};
    assign norm   = prod[2*MW+1];
    assign mant   = norm ? prod[2*MW -: MW] : prod[2*MW-1 -: MW];
    assign guard  = norm ? prod[MW] : prod[MW-1];
    assign sticky = norm ? |prod[MW-1:0] : |prod[MW-2:0];
    assign rnd    = guard & (sticky | mant[0]);
    // a rounding carry leaves the mantissa field all zero, so only the exponent needs bumping
    assign mant_r = {1'b0, mant} + {{MW{1'b0}}, rnd};
    assign e_res  = 10'(ea) + 10'(eb) - 10'(BIAS) + 10'(norm) + 10'(mant_r[MW]);

    always_comb begin
        res_d = '0;
        exc_d = 1'b0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        res_d[BIT_WIDTH-1] = sign;
        if (ea == EMAX || eb == EMAX) begin
            exc_d = 1'b1;
            res_d[MT +: EW] = EMAX;
            if (a_nan || b_nan || a_zero || b_zero)
                res_d = 32'h7FC0_0000;
        end else if (!a_zero && !b_zero) begin
            if (!e_res[9] && e_res >= 10'(EMAX)) begin
                ovf_d = 1'b1;
                res_d[MT +: EW] = EMAX;
            end else if (e_res[9] || e_res == '0) begin
                unf_d = 1'b1;
            end else begin
                res_d[MT +: EW]   = e_res[EW-1:0];
                res_d[MT-1 -: MW] = mant_r[MW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst)
            {result, exception, overflow, underflow} <= '0;
        else
            {result, exception, overflow, underflow} <= {res_d, exc_d, ovf_d, unf_d};
endmodule

// File: tb/tb_fpmult32_top.sv
// tb_fpmult32_top: scoreboard bench for fpmult32_top (FP32 build); expected values are queued at drive time.
module tb_fpmult32_top;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a_op = '0, b_op = '0;
    logic [31:0] result;
    logic        exception, overflow, underflow;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [34:0] v;
        string       tag;
    } ent_t;
    ent_t sb[$];

    fpmult32_top dut (
        .clk(clk), .rst(rst), .a_operand(a_op), .b_operand(b_op),
        .result(result), .exception(exception), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // {exception, overflow, underflow, result} from an integer-arithmetic FTZ/RNE reference
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
        logic s = a[31] ^ b[31];
        int ea = int'(a[30:23]);
        int eb = int'(b[30:23]);
        longint unsigned fa = longint'(a[22:0]);
        longint unsigned fb = longint'(b[22:0]);
        longint unsigned p, q, r, half;
        int e, sh;
        if (ea == 255 || eb == 255) begin
            if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) || ea == 0 || eb == 0)
                return {3'b100, 32'h7FC0_0000};
            return {3'b100, s, 8'hFF, 23'h0};
        end
        if (ea == 0 || eb == 0)
            return {3'b000, s, 31'h0};
        p  = (fa + 64'd8388608) * (fb + 64'd8388608);
        e  = ea + eb - 127;
        sh = 23;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e++;
        end
        q    = p >> sh;
        r    = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (r > half || (r == half && (q & 64'd1) != 0))
            q++;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255)
            return {3'b010, s, 8'hFF, 23'h0};
        if (e <= 0)
            return {3'b001, s, 31'h0};
        return {3'b000, s, e[7:0], q[22:0]};
    endfunction

    task automatic check_out();
        ent_t x;
        if (sb.size() != 0) begin
            x = sb.pop_front();
            checks++;
            assert ({exception, overflow, underflow, result} === x.v)
            else begin
                errors++;
                $error("FAIL %s: got exc/ovf/unf/result=%b%b%b/%h want %b%b%b/%h", x.tag,
                       exception, overflow, underflow, result, x.v[34], x.v[33], x.v[32], x.v[31:0]);
            end
        end
    endtask

    // drive one pair on the falling edge; the previous pair's result is checked first
    task automatic cycle(input logic [31:0] a, input logic [31:0] b, input logic [34:0] v, input string tag);
        ent_t x;
        @(negedge clk);
        check_out();
        a_op = a;
        b_op = b;
        x.v = v;
        x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic flush();
        @(negedge clk);
        check_out();
    endtask

    task automatic rand_pair(input bit near_one);
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        if (near_one) begin
            a[30:23] = 8'($urandom_range(100, 154));
            b[30:23] = 8'($urandom_range(100, 154));
        end
        cycle(a, b, model(a, b), near_one ? "rand_near" : "rand_full");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checks++;
        assert ({exception, overflow, underflow, result} === 35'h0)
        else begin
            errors++;
            $error("FAIL reset_init: got %h want 0", {exception, overflow, underflow, result});
        end
        rst = 1'b0;

        cycle(32'h4000_0000, 32'h4040_0000, {3'b000, 32'h40C0_0000}, "2x3");
        cycle(32'h3FC0_0000, 32'h3FC0_0000, {3'b000, 32'h4010_0000}, "1.5x1.5");
        cycle(32'hBF80_0000, 32'h3F80_0000, {3'b000, 32'hBF80_0000}, "neg1x1");
        cycle(32'h3F80_0001, 32'h3F80_0001, {3'b000, 32'h3F80_0002}, "rne_sticky");
        cycle(32'h3FFF_FFFF, 32'h3FFF_FFFF, {3'b000, 32'h407F_FFFE}, "rne_max");
        cycle(32'h7F7F_FFFF, 32'h4000_0000, {3'b010, 32'h7F80_0000}, "overflow");
        cycle(32'h0080_0000, 32'h3F00_0000, {3'b001, 32'h0000_0000}, "underflow_pos");
        cycle(32'h8080_0000, 32'h3F00_0000, {3'b001, 32'h8000_0000}, "underflow_neg");
        cycle(32'h7F80_0000, 32'h0000_0000, {3'b100, 32'h7FC0_0000}, "inf_x_zero");
        cycle(32'hFF80_0000, 32'h4000_0000, {3'b100, 32'hFF80_0000}, "ninf_x_2");
        cycle(32'h7FC0_0001, 32'h3F80_0000, {3'b100, 32'h7FC0_0000}, "nan_x_1");
        cycle(32'h8000_0000, 32'h4000_0000, {3'b000, 32'h8000_0000}, "negzero_x_2");
        cycle(32'h0000_0001, 32'h4000_0000, {3'b000, 32'h0000_0000}, "subnorm_ftz");
        cycle(32'h7F80_0000, 32'hFF80_0000, {3'b100, 32'hFF80_0000}, "inf_x_ninf");
        cycle(32'h3F80_0000, 32'h3F80_0000, {3'b000, 32'h3F80_0000}, "1x1");
        flush();

        cycle(32'h4000_0000, 32'h4040_0000, {3'b000, 32'h40C0_0000}, "pre_reset");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        assert ({exception, overflow, underflow, result} === 35'h0)
        else begin
            errors++;
            $error("FAIL reset_async: got %h want 0", {exception, overflow, underflow, result});
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 1000; i++)
            rand_pair(i[0]);
        flush();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
